register_8_rx: RTL and testbench

//  Serial receive end of the 8-bit shift-register path: deserializes a bit

---
 rtl/register_8_rx_pkg.sv | 11 +
 rtl/rx_gap_timer.sv | 25 ++
 rtl/register_8_rx.sv | 111 +++++++++++
 tb/tb_register_8_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/register_8_rx_pkg.sv
// register_8_rx_pkg: shared FSM state encoding and S_TOP mode-word field indices
package register_8_rx_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
    localparam int S_EN  = 0;
    localparam int S_LSB = 1;
    localparam int S_PAR = 2;
endpackage

// File: rtl/rx_gap_timer.sv
// rx_gap_timer: counts idle cycles between strobes, flags the cycle that reaches TIMEOUT
module rx_gap_timer
    import register_8_rx_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int GW = $clog2(TIMEOUT + 1);
    logic [GW-1:0] r_gap;
    assign o_expire = i_en && (r_gap == GW'(TIMEOUT - 1));
    // gap counter: cleared on strobe or outside a frame, else counts idle cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_gap <= '0;
        else if (i_clr)
            r_gap <= '0;
        else if (i_en)
            r_gap <= r_gap + GW'(1);
    end
endmodule

// File: rtl/register_8_rx.sv
// register_8_rx: serial-to-parallel receiver with optional parity, gap timeout and VALID/ACK hold
module register_8_rx
    import register_8_rx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int TIMEOUT    = 16
) (
    input  logic             CLK_TOP,
    input  logic             RST_TOP,
    input  logic [2:0]       S_TOP,
    input  logic             SIN_TOP,
    input  logic             SEN_TOP,
    input  logic             DACK_TOP,
    output logic [WIDTH-1:0] DOUT_TOP,
    output logic             DVALID_TOP,
    output logic             PERR_TOP,
    output logic             OVR_TOP,
    output logic             FERR_TOP,
    output logic             BUSY_TOP
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sh, w_shifted, w_data, r_dout;
    logic [CW-1:0]    r_cnt;
    logic             r_lsb, r_par, r_dvalid, r_perr, r_ovr, r_ferr;
    logic             w_busy, w_start, w_shift, w_last, w_done, w_lsb, w_perr, w_expire;

    assign w_busy    = r_state != ST_IDLE;
    assign w_start   = r_state == ST_IDLE && SEN_TOP && S_TOP[S_EN];
    assign w_shift   = r_state == ST_SHIFT && SEN_TOP;
    assign w_last    = w_shift && r_cnt == CW'(WIDTH - 1);
    assign w_done    = (w_last && !r_par) || (r_state == ST_PAR && SEN_TOP);
    // the first strobe uses the live mode word, later strobes the latched copy
    assign w_lsb     = r_state == ST_IDLE ? S_TOP[S_LSB] : r_lsb;
    assign w_shifted = w_lsb ? {SIN_TOP, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], SIN_TOP};
    assign w_data    = r_state == ST_PAR ? r_sh : w_shifted;
    assign w_perr    = r_state == ST_PAR && ((^r_sh ^ SIN_TOP) != PARITY_ODD);

    rx_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
        .i_clk   (CLK_TOP),
        .i_rst   (RST_TOP),
        .i_clr   (!w_busy || SEN_TOP),
        .i_en    (w_busy && !SEN_TOP),
        .o_expire(w_expire)
    );

    // state register
    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // next-state: a timeout always wins over waiting for the next strobe
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_next = w_expire ? ST_IDLE : w_last ? (r_par ? ST_PAR : ST_IDLE) : ST_SHIFT;
            ST_PAR:   w_next = (w_expire || SEN_TOP) ? ST_IDLE : ST_PAR;
            default:  w_next = ST_IDLE;
        endcase
    end

    // shifter, mode latch and output hold register with overrun/timeout pulses
    always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
        if (RST_TOP) begin
            r_sh     <= '0;
            r_cnt    <= '0;
            r_lsb    <= 1'b0;
            r_par    <= 1'b0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_ovr  <= 1'b0;
            r_ferr <= w_expire;
            if (w_start) begin
                r_lsb <= S_TOP[S_LSB];
                r_par <= S_TOP[S_PAR];
                r_cnt <= CW'(1);
            end else if (w_shift) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_start || w_shift)
                r_sh <= w_shifted;
            if (w_done) begin
                if (!r_dvalid || DACK_TOP) begin
                    r_dout   <= w_data;
                    r_perr   <= w_perr;
                    r_dvalid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_dvalid && DACK_TOP) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    assign DOUT_TOP   = r_dout;
    assign DVALID_TOP = r_dvalid;
    assign PERR_TOP   = r_perr;
    assign OVR_TOP    = r_ovr;
    assign FERR_TOP   = r_ferr;
    assign BUSY_TOP   = w_busy;
endmodule

// File: tb/tb_register_8_rx.sv
// tb_register_8_rx: directed and randomized frames checked against a frame-level model
module tb_register_8_rx;
    localparam int WIDTH      = 8;
    localparam int PARITY_ODD = 0;
    localparam int TIMEOUT    = 16;

    logic             CLK_TOP = 1'b0;
    logic             RST_TOP, SIN_TOP, SEN_TOP, DACK_TOP;
    logic [2:0]       S_TOP;
    logic [WIDTH-1:0] DOUT_TOP;
    logic             DVALID_TOP, PERR_TOP, OVR_TOP, FERR_TOP, BUSY_TOP;

    int               total = 0;
    int               bad = 0;
    logic             bq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid, m_perr;

    register_8_rx #(.WIDTH(WIDTH), .PARITY_ODD(1'(PARITY_ODD)), .TIMEOUT(TIMEOUT)) dut (
        .CLK_TOP   (CLK_TOP),
        .RST_TOP   (RST_TOP),
        .S_TOP     (S_TOP),
        .SIN_TOP   (SIN_TOP),
        .SEN_TOP   (SEN_TOP),
        .DACK_TOP  (DACK_TOP),
        .DOUT_TOP  (DOUT_TOP),
        .DVALID_TOP(DVALID_TOP),
        .PERR_TOP  (PERR_TOP),
        .OVR_TOP   (OVR_TOP),
        .FERR_TOP  (FERR_TOP),
        .BUSY_TOP  (BUSY_TOP)
    );

    always #5 CLK_TOP = ~CLK_TOP;

    task automatic tick();
        @(posedge CLK_TOP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_ovr, input logic e_ferr, input logic e_busy);
        chk($sformatf("%s.dvalid", tag), 32'(DVALID_TOP), 32'(m_valid));
        if (m_valid) begin
            chk($sformatf("%s.dout", tag), 32'(DOUT_TOP), 32'(m_dout));
            chk($sformatf("%s.perr", tag), 32'(PERR_TOP), 32'(m_perr));
        end
        chk($sformatf("%s.ovr", tag), 32'(OVR_TOP), 32'(e_ovr));
        chk($sformatf("%s.ferr", tag), 32'(FERR_TOP), 32'(e_ferr));
        chk($sformatf("%s.busy", tag), 32'(BUSY_TOP), 32'(e_busy));
    endtask

    task automatic set_bits(input logic [15:0] v, input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(v[n-1-i]);
    endtask

    task automatic strobe(input logic b);
        SIN_TOP = b;
        SEN_TOP = 1'b1;
        tick();
        SEN_TOP = 1'b0;
        SIN_TOP = 1'($urandom);
    endtask

    task automatic send(input logic [2:0] mode, input logic ack_last, input int gapmax, input bit scramble);
        int               n;
        logic [WIDTH-1:0] byt;
        logic             pbit, perr, ovr;
        n = mode[2] ? WIDTH + 1 : WIDTH;
        for (int i = 0; i < WIDTH; i++)
            if (mode[1]) byt[i] = bq[i]; else byt[WIDTH-1-i] = bq[i];
        pbit = mode[2] ? bq[WIDTH] : 1'b0;
        perr = mode[2] && ((($countones(byt) + int'(pbit)) % 2) != PARITY_ODD);
        for (int i = 0; i < n; i++) begin
            S_TOP    = (i == 0 || !scramble) ? mode : 3'($urandom);
            DACK_TOP = (i == n - 1) ? ack_last : 1'b0;
            strobe(bq[i]);
            DACK_TOP = 1'b0;
            if (i < n - 1) begin
                chk("busy_mid", 32'(BUSY_TOP), 32'd1);
                repeat ($urandom_range(0, gapmax)) tick();
            end
        end
        ovr = m_valid && !ack_last;
        if (!ovr) begin
            m_dout = byt;
            m_perr = perr;
        end
        m_valid = 1'b1;
        chk_out("done", ovr, 1'b0, 1'b0);
        tick();
        chk("ovr_clear", 32'(OVR_TOP), 32'd0);
    endtask

    task automatic ack();
        DACK_TOP = 1'b1;
        tick();
        DACK_TOP = 1'b0;
        m_valid = 1'b0;
        chk("ack", 32'(DVALID_TOP), 32'd0);
    endtask

    initial begin
        RST_TOP = 1'b1; S_TOP = 3'b000; SIN_TOP = 1'b0; SEN_TOP = 1'b0; DACK_TOP = 1'b0;
        m_dout = '0; m_valid = 1'b0; m_perr = 1'b0;
        repeat (2) tick();
        chk("rst.dout", 32'(DOUT_TOP), 32'd0);
        chk("rst.perr", 32'(PERR_TOP), 32'd0);
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        RST_TOP = 1'b0;
        tick();

        // disabled mode: strobes ignored
        S_TOP = 3'b000;
        for (int i = 0; i < WIDTH; i++) begin
            strobe(1'b1);
            chk("dis.busy", 32'(BUSY_TOP), 32'd0);
        end
        chk_out("dis", 1'b0, 1'b0, 1'b0);

        // MSB-first A5, held until ack
        set_bits(16'hA5, 8);
        send(3'b001, 1'b0, 0, 0);
        chk("t1.A5", 32'(DOUT_TOP), 32'hA5);
        repeat (3) tick();
        chk_out("t1.hold", 1'b0, 1'b0, 1'b0);
        ack();

        // LSB-first
        set_bits(16'b1100_0000, 8);
        send(3'b011, 1'b0, 0, 0);
        chk("t2.03", 32'(DOUT_TOP), 32'h03);
        ack();

        // parity: 01 with parity 0 is an error, with parity 1 it is not
        set_bits(16'b0000_0001_0, 9);
        send(3'b101, 1'b0, 0, 0);
        chk("t3.perr1", 32'(PERR_TOP), 32'd1);
        ack();
        set_bits(16'b0000_0001_1, 9);
        send(3'b101, 1'b0, 0, 0);
        chk("t3.perr0", 32'(PERR_TOP), 32'd0);
        ack();

        // overrun, then ack coinciding with completion
        set_bits(16'h11, 8); send(3'b001, 1'b0, 0, 0);
        set_bits(16'h22, 8); send(3'b001, 1'b0, 0, 0);
        chk("t4.keep11", 32'(DOUT_TOP), 32'h11);
        ack();
        set_bits(16'h11, 8); send(3'b001, 1'b0, 0, 0);
        set_bits(16'h22, 8); send(3'b001, 1'b1, 0, 0);
        chk("t4.load22", 32'(DOUT_TOP), 32'h22);
        ack();

        // timeout after 3 bits
        S_TOP = 3'b001;
        strobe(1'b1); strobe(1'b0); strobe(1'b1);
        repeat (TIMEOUT - 1) tick();
        chk_out("t5.pre", 1'b0, 1'b0, 1'b1);
        tick();
        chk_out("t5.ferr", 1'b0, 1'b1, 1'b0);
        tick();
        chk("t5.ferr_clear", 32'(FERR_TOP), 32'd0);
        set_bits(16'h3C, 8); send(3'b001, 1'b0, 0, 0);
        chk("t5.3C", 32'(DOUT_TOP), 32'h3C);

        // async reset mid-frame with a byte still pending
        S_TOP = 3'b001;
        repeat (5) strobe(1'b1);
        #3 RST_TOP = 1'b1;
        #1;
        m_dout = '0; m_valid = 1'b0; m_perr = 1'b0;
        chk("t6.dout", 32'(DOUT_TOP), 32'd0);
        chk("t6.perr", 32'(PERR_TOP), 32'd0);
        chk_out("t6.rst", 1'b0, 1'b0, 1'b0);
        tick();
        RST_TOP = 1'b0;
        tick();
        set_bits(16'hFF, 8); send(3'b001, 1'b0, 0, 0);
        chk("t6.FF", 32'(DOUT_TOP), 32'hFF);
        ack();

        // random frames: mode, data, parity bit, gaps, mid-frame mode noise, ack timing
        for (int f = 0; f < 40; f++) begin
            bq.delete();
            for (int i = 0; i <= WIDTH; i++) bq.push_back(1'($urandom));
            send(3'($urandom_range(0, 3) * 2 + 1), 1'($urandom), 3, 1);
            if ($urandom_range(0, 1) == 1) ack();
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
